// File: rtl/mux_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux_rr_arbiter
//   Round-robin, packet-locked arbiter that shares one N:1 W-bit mux between
//   N valid/ready requesters and a single downstream valid/ready channel.
//   A requester wins arbitration in IDLE (one bubble cycle), then owns the
//   channel until it transfers a beat with in_last=1.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active low
//   in_valid   per-requester valid                  [N]
//   in_data    requester i data in [i*W +: W]       [N*W]
//   in_last    per-requester last-beat flag         [N]
//   in_ready   per-requester ready, at most one set [N]
//   out_valid  shared channel valid
//   out_data   muxed data of the granted requester  [W]
//   out_last   muxed last of the granted requester
//   out_ready  downstream ready
//   grant      registered one-hot grant, 0 when idle [N]
//   busy       high while a grant is held (LOCKED)
// ---------------------------------------------------------------------------
module mux_rr_arbiter #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_last,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic           out_last,
  input  logic           out_ready,
  output logic [N-1:0]   grant,
  output logic           busy
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          r_state;
  logic [N-1:0]    r_grant;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_grantIdx;

  logic            w_anyValid;
  logic            w_found;
  logic [PW-1:0]   w_selIdx;
  logic [PW-1:0]   w_scanIdx;
  logic            w_locked;
  logic [W-1:0]    w_muxData;
  logic [N-1:0]    w_ready;
  logic            w_beatDone;

  // Priority search starting at r_ptr and wrapping modulo N. The scan index
  // is stepped explicitly so non-power-of-two N wraps correctly.
  always_comb begin
    w_found    = 1'b0;
    w_selIdx   = '0;
    w_scanIdx  = r_ptr;
    w_anyValid = |in_valid;
    for (int k = 0; k < N; k++) begin
      if (!w_found && in_valid[w_scanIdx]) begin
        w_found  = 1'b1;
        w_selIdx = w_scanIdx;
      end
      w_scanIdx = (w_scanIdx == PW'(N-1)) ? '0 : w_scanIdx + 1'b1;
    end
  end

  // Data mux keyed on the registered grant index; forced to zero when idle.
  always_comb begin
    w_muxData = '0;
    for (int i = 0; i < N; i++) begin
      if (w_locked && (r_grantIdx == PW'(i))) begin
        w_muxData = in_data[i*W +: W];
      end
    end
  end

  // Only the granted requester can ever see ready.
  always_comb begin
    w_ready = '0;
    if (w_locked) begin
      w_ready[r_grantIdx] = out_ready;
    end
  end

  assign w_locked   = (r_state == LOCKED);
  assign w_beatDone = w_locked && in_valid[r_grantIdx] && out_ready;

  assign out_valid = w_locked && in_valid[r_grantIdx];
  assign out_last  = w_locked && in_last[r_grantIdx];
  assign out_data  = w_muxData;
  assign in_ready  = w_ready;
  assign grant     = r_grant;
  assign busy      = w_locked;

  // Arbitration FSM. The pointer only advances past the granted requester
  // once its last beat has actually transferred, which gives the fairness
  // rotation; a reset abandons any packet in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_ptr      <= '0;
      r_grantIdx <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_anyValid && w_found) begin
            r_state    <= LOCKED;
            r_grant    <= N'(1) << w_selIdx;
            r_grantIdx <= w_selIdx;
          end
        end
        LOCKED: begin
          if (w_beatDone && in_last[r_grantIdx]) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_ptr   <= (r_grantIdx == PW'(N-1)) ? '0 : r_grantIdx + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux_rr_arbiter
//   Directed bench for mux_rr_arbiter (N=4, W=8). Inputs change 1ns after
//   the rising edge and outputs are sampled 3ns later, well before the next
//   edge, so each check sees the state registered at the previous edge.
// ---------------------------------------------------------------------------
module tb_mux_rr_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_last;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic           out_ready;
  logic [N-1:0]   grant;
  logic           busy;

  int testsRun;
  int testsFailed;

  mux_rr_arbiter #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .grant     (grant),
    .busy      (busy)
  );

  // 10ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling
  task automatic settle();
    #3;
  endtask

  // Two reset cycles with quiet inputs, then release; DUT is IDLE, ptr=0
  task automatic do_reset();
    rst       = 1'b0;
    in_valid  = '0;
    in_last   = '0;
    in_data   = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    in_valid  = 4'b1111;
    in_last   = 4'b1111;
    in_data   = 32'h44332211;
    out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      settle();
      testsRun++;
      if (grant !== 4'b0000) begin testsFailed++; $display("[TB] FAIL reset_grant: got %b expected %b", grant, 4'b0000); end
      testsRun++;
      if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy: got %b expected %b", busy, 1'b0); end
      testsRun++;
      if (out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_out_valid: got %b expected %b", out_valid, 1'b0); end
      testsRun++;
      if (in_ready !== 4'b0000) begin testsFailed++; $display("[TB] FAIL reset_in_ready: got %b expected %b", in_ready, 4'b0000); end
      testsRun++;
      if (out_data !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_out_data: got %h expected %h", out_data, 8'h00); end
    end
    rst = 1'b1;
    tick();
    settle();
    testsRun++;
    if (grant !== 4'b0001) begin testsFailed++; $display("[TB] FAIL reset_first_grant: got %b expected %b", grant, 4'b0001); end
  endtask

  task automatic test_single();
    logic [7:0] beats [3];
    beats[0] = 8'hA1;
    beats[1] = 8'hA2;
    beats[2] = 8'hA3;
    do_reset();
    in_valid  = 4'b0100;
    in_last   = 4'b0000;
    in_data[2*W +: W] = beats[0];
    out_ready = 1'b1;
    settle();
    testsRun++;
    if (grant !== 4'b0000 || out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_bubble: got grant=%b valid=%b expected grant=0000 valid=0", grant, out_valid); end
    for (int b = 0; b < 3; b++) begin
      tick();
      in_data[2*W +: W] = beats[b];
      in_last = (b == 2) ? 4'b0100 : 4'b0000;
      settle();
      testsRun++;
      if (out_data !== beats[b]) begin testsFailed++; $display("[TB] FAIL single_data%0d: got %h expected %h", b, out_data, beats[b]); end
      testsRun++;
      if (in_ready !== 4'b0100) begin testsFailed++; $display("[TB] FAIL single_ready%0d: got %b expected %b", b, in_ready, 4'b0100); end
    end
    testsRun++;
    if (out_last !== 1'b1) begin testsFailed++; $display("[TB] FAIL single_last: got %b expected %b", out_last, 1'b1); end
    tick();
    in_valid = 4'b0000;
    in_last  = 4'b0000;
    settle();
    testsRun++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_release: got grant=%b busy=%b expected grant=0000 busy=0", grant, busy); end
    // Everyone requests; the pointer should now favour requester 3
    in_valid = 4'b1111;
    in_last  = 4'b1111;
    tick();
    settle();
    testsRun++;
    if (grant !== 4'b1000) begin testsFailed++; $display("[TB] FAIL single_ptr3: got %b expected %b", grant, 4'b1000); end
  endtask

  task automatic test_round_robin();
    logic [3:0] expGrant [5];
    logic [7:0] expData  [5];
    expGrant[0] = 4'b0001; expData[0] = 8'h10;
    expGrant[1] = 4'b0010; expData[1] = 8'h11;
    expGrant[2] = 4'b0100; expData[2] = 8'h12;
    expGrant[3] = 4'b1000; expData[3] = 8'h13;
    expGrant[4] = 4'b0001; expData[4] = 8'h10;
    do_reset();
    in_valid  = 4'b1111;
    in_last   = 4'b1111;
    in_data   = 32'h13121110;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      settle();
      testsRun++;
      if (grant !== expGrant[k] || out_data !== expData[k]) begin testsFailed++; $display("[TB] FAIL rr_grant%0d: got grant=%b data=%h expected grant=%b data=%h", k, grant, out_data, expGrant[k], expData[k]); end
      tick();
      settle();
      testsRun++;
      if (grant !== 4'b0000) begin testsFailed++; $display("[TB] FAIL rr_idle%0d: got %b expected %b", k, grant, 4'b0000); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    in_valid  = 4'b0010;
    in_last   = 4'b0010;
    in_data[1*W +: W] = 8'h5C;
    out_ready = 1'b0;
    tick();
    for (int c = 0; c < 3; c++) begin
      settle();
      testsRun++;
      if (out_valid !== 1'b1 || in_ready !== 4'b0000 || grant !== 4'b0010 || out_data !== 8'h5C) begin
        testsFailed++;
        $display("[TB] FAIL bp_hold%0d: got valid=%b ready=%b grant=%b data=%h expected valid=1 ready=0000 grant=0010 data=5c", c, out_valid, in_ready, grant, out_data);
      end
      tick();
    end
    out_ready = 1'b1;
    settle();
    testsRun++;
    if (in_ready !== 4'b0010) begin testsFailed++; $display("[TB] FAIL bp_release_ready: got %b expected %b", in_ready, 4'b0010); end
    tick();
    in_valid = 4'b0000;
    settle();
    testsRun++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL bp_done: got grant=%b busy=%b expected grant=0000 busy=0", grant, busy); end
  endtask

  task automatic test_lock_gap();
    do_reset();
    in_valid  = 4'b1001;
    in_last   = 4'b1000;
    in_data   = 32'h33000001;
    out_ready = 1'b1;
    tick();
    settle();
    testsRun++;
    if (grant !== 4'b0001 || out_data !== 8'h01) begin testsFailed++; $display("[TB] FAIL gap_first: got grant=%b data=%h expected grant=0001 data=01", grant, out_data); end
    tick();
    in_valid = 4'b1000;
    for (int c = 0; c < 2; c++) begin
      settle();
      testsRun++;
      if (out_valid !== 1'b0 || grant !== 4'b0001 || in_ready[3] !== 1'b0) begin testsFailed++; $display("[TB] FAIL gap_hold%0d: got valid=%b grant=%b ready=%b expected valid=0 grant=0001 ready3=0", c, out_valid, grant, in_ready); end
      tick();
    end
    in_valid = 4'b1001;
    in_last  = 4'b1001;
    in_data[0 +: W] = 8'h02;
    settle();
    testsRun++;
    if (out_valid !== 1'b1 || out_data !== 8'h02 || out_last !== 1'b1) begin testsFailed++; $display("[TB] FAIL gap_last: got valid=%b data=%h last=%b expected valid=1 data=02 last=1", out_valid, out_data, out_last); end
    tick();
    in_valid = 4'b1000;
    settle();
    testsRun++;
    if (grant !== 4'b0000) begin testsFailed++; $display("[TB] FAIL gap_bubble: got %b expected %b", grant, 4'b0000); end
    tick();
    settle();
    testsRun++;
    if (grant !== 4'b1000 || out_data !== 8'h33) begin testsFailed++; $display("[TB] FAIL gap_req3: got grant=%b data=%h expected grant=1000 data=33", grant, out_data); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    // One single-beat packet from requester 0 moves ptr to 1
    in_valid  = 4'b0001;
    in_last   = 4'b0001;
    in_data   = 32'h00000077;
    out_ready = 1'b1;
    tick();
    tick();
    in_valid = 4'b0010;
    in_last  = 4'b0000;
    in_data[1*W +: W] = 8'hB1;
    tick();
    settle();
    testsRun++;
    if (grant !== 4'b0010 || out_data !== 8'hB1) begin testsFailed++; $display("[TB] FAIL mid_beat1: got grant=%b data=%h expected grant=0010 data=b1", grant, out_data); end
    tick();
    in_data[1*W +: W] = 8'hB2;
    rst = 1'b0;
    tick();
    rst      = 1'b1;
    in_valid = 4'b1111;
    in_last  = 4'b1111;
    settle();
    testsRun++;
    if (grant !== 4'b0000 || busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 4'b0000) begin
      testsFailed++;
      $display("[TB] FAIL mid_reset: got grant=%b busy=%b valid=%b ready=%b expected all zero", grant, busy, out_valid, in_ready);
    end
    tick();
    settle();
    testsRun++;
    if (grant !== 4'b0001) begin testsFailed++; $display("[TB] FAIL mid_ptr0: got %b expected %b", grant, 4'b0001); end
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst       = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    in_last   = '0;
    out_ready = 1'b0;
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_lock_gap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin arbiter that shares one N:1 W-bit mux between N valid/ready requesters and drives a single valid/ready output channel.
- Grants are packet-locked: a grant is held until the granted requester completes a beat with in_last=1.
- Sits in front of any shared single-port sink (bus, FIFO write port, serializer) and is the controller for the mux primitive.

Parameters:
- N, 4, number of requesters (N >= 2).
- W, 8, data width per requester.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-low (rst=0 resets on the next rising edge of clk).
- in_valid  input  N  per-requester valid.
- in_data  input  N*W  requester i data in bits [i*W +: W].
- in_last  input  N  per-requester last-beat-of-packet flag.
- in_ready  output  N  per-requester ready; at most one bit set.
- out_valid  output  1  shared channel valid.
- out_data  output  W  shared channel data, which is the muxed in_data of the granted requester.
- out_last  output  1  muxed in_last of the granted requester.
- out_ready  input  1  downstream ready.
- grant  output  N  registered one-hot grant; all zeros when idle.
- busy  output  1  1 while in the LOCKED state.

Behaviour:
- Reset (rst=0 at an edge): state=IDLE, grant=0, ptr=0, busy=0.
  - Because grant=0 after reset, out_valid=0, in_ready=0, out_data=0 and out_last=0.
  - A reset applied mid-packet abandons the packet; no beat is transferred in the reset cycle.
- State register has two states, IDLE and LOCKED. Rotating priority pointer ptr is in range 0..N-1.
- IDLE:
  - Outputs out_valid=0 and in_ready=0.
  - If any in_valid bit is set, select the first requester i with in_valid[i]=1, searching ptr, ptr+1, ... mod N.
  - On the next edge: grant = one-hot(i), state=LOCKED.
  - If no in_valid bit is set, stay in IDLE.
  - Arbitration costs exactly 1 bubble cycle per packet.
- LOCKED with granted index g:
  - out_valid = in_valid[g], out_data = in_data[g], out_last = in_last[g] (combinational through the mux).
  - in_ready[g] = out_ready; all other in_ready bits are 0.
  - A beat transfers when in_valid[g] and out_ready are both 1.
  - If a transferred beat has in_last[g]=1: on that edge state=IDLE, grant=0, ptr=(g+1) mod N.
  - Otherwise stay LOCKED with the grant unchanged.
  - If in_valid[g] drops mid-packet: out_valid=0 and the grant is held. No timeout and no preemption.
- Non-granted requesters never see in_ready=1. Their in_valid and in_data changes have no effect on the output.
- Requesters must hold valid, data and last stable while valid=1 and ready=0; the arbiter does not check this.
- Ptr update: ptr changes only on completion of a last beat. A single-beat packet has in_last=1 on its only beat.
- Fairness: with all requesters continuously requesting single-beat packets, grants cycle 0,1,2,...,N-1,0.
- Ptr wrap: ptr wraps from N-1 to 0.
- Latency:
  - Data path from granted input to output is 0 cycles (combinational).
  - Grant decision takes 1 cycle from IDLE.
  - Back-to-back single-beat packets give a throughput of 1 beat per 2 cycles.

Test Plan:
- Reset: hold rst=0 for 2 cycles with all in_valid=1 -> grant=0, busy=0, out_valid=0 and in_ready=0 during reset. Release, then 1 cycle later grant=4'b0001.
- Single requester: N=4, W=8; only requester 2 sends a 3-beat packet A1, A2, A3 (last on A3) with out_ready=1 -> IDLE 1 cycle, then out_data=A1, A2, A3 on consecutive cycles, in_ready=4'b0100 during those cycles, then grant=0 and next search starts at ptr=3.
- Round-robin: all four in_valid=1 continuously with single-beat packets and out_ready=1 -> grant sequence 0001, 0010, 0100, 1000, 0001, with idle cycles between grants.
- Backpressure: requester 1 is locked and out_ready=0 for 3 cycles with in_valid[1]=1 -> out_valid=1, in_ready=0, grant held and out_data stable. When out_ready=1 the beat transfers.
- Lock and gap: requester 0 mid-packet drops in_valid for 2 cycles while requester 3 is valid -> out_valid=0 and grant stays 0001. Requester 3 is granted only after requester 0's last beat plus 1 idle cycle.
- Reset mid-packet: assert rst=0 during beat 2 of a 4-beat packet from requester 1 -> no transfer in that cycle, grant=0 and ptr=0 after reset, and the next arbitration starts from requester 0.
